// File: rtl/trd_sched_if.sv
// Thread-scheduler bus: stall, redirect, thread-control request, spawn grant
// and fetch issue. The scheduler uses the slave side, whoever drives the
// control path and consumes fetch uses the master side.
interface trd_sched_if #(
    parameter int NTRD = 8
);
    logic            stall;
    logic            jmp_en;
    logic [2:0]      jmp_trd;
    logic [31:0]     jmp_pc;
    logic            ctrl_vld;
    logic [1:0]      ctrl_op;
    logic [2:0]      ctrl_trd;
    logic [31:0]     ctrl_pc;
    logic [2:0]      new_trd;
    logic            new_trd_vld;
    logic            fetch_vld;
    logic [2:0]      fetch_trd;
    logic [31:0]     fetch_pc;
    logic [NTRD-1:0] active_mask;

    modport master (
        output stall, jmp_en, jmp_trd, jmp_pc,
        output ctrl_vld, ctrl_op, ctrl_trd, ctrl_pc,
        input  new_trd, new_trd_vld,
        input  fetch_vld, fetch_trd, fetch_pc, active_mask
    );

    modport slave (
        input  stall, jmp_en, jmp_trd, jmp_pc,
        input  ctrl_vld, ctrl_op, ctrl_trd, ctrl_pc,
        output new_trd, new_trd_vld,
        output fetch_vld, fetch_trd, fetch_pc, active_mask
    );
endinterface

// File: rtl/trd_sched.sv
// Hardware thread scheduler: per-thread state and PC, round-robin issue of
// one runnable thread per unstalled cycle, spawn/kill/sleep/wake control and
// execute-stage jump redirects.
module trd_sched #(
    parameter int          NTRD     = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    trd_sched_if.slave bus
);
    typedef enum logic [1:0] {
        TRD_FREE  = 2'd0,
        TRD_RUN   = 2'd1,
        TRD_SLEEP = 2'd2
    } trd_state_t;

    // Tables are always 8 deep so the 3-bit thread ids index them directly;
    // entries at or above NTRD stay FREE forever and are never allocated.
    trd_state_t  state_reg  [8];
    trd_state_t  state_next [8];
    logic [31:0] pc_reg     [8];
    logic [31:0] pc_next    [8];

    logic [7:0]  kill_hit, sleep_hit, wake_hit, spawn_hit;
    logic [7:0]  jmp_hit, issue_hit, elig;

    logic            spawn_req;
    logic            spawn_found;
    logic [2:0]      spawn_id;
    logic            sel_vld;
    logic [2:0]      sel_trd;
    logic [31:0]     sel_pc;
    logic [NTRD-1:0] active_next;

    logic            fetch_vld_reg;
    logic [2:0]      fetch_trd_reg;
    logic [31:0]     fetch_pc_reg;
    logic [2:0]      last_trd_reg;
    logic [NTRD-1:0] active_mask_reg;

    assign spawn_req = bus.ctrl_vld && (bus.ctrl_op == 2'b00);

    // Lowest-id FREE thread, judged on the current state.
    always_comb begin
        spawn_found = 1'b0;
        spawn_id    = 3'd0;
        for (int i = NTRD - 1; i >= 0; i--) begin
            if (state_reg[i] == TRD_FREE) begin
                spawn_found = 1'b1;
                spawn_id    = 3'(i);
            end
        end
    end

    assign bus.new_trd_vld = spawn_req && spawn_found;
    assign bus.new_trd     = bus.new_trd_vld ? spawn_id : 3'd0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_trd
            localparam logic [2:0] ID = 3'(gi);

            assign kill_hit[gi]  = bus.ctrl_vld && (bus.ctrl_op == 2'b01) && (bus.ctrl_trd == ID);
            assign sleep_hit[gi] = bus.ctrl_vld && (bus.ctrl_op == 2'b10) && (bus.ctrl_trd == ID);
            assign wake_hit[gi]  = bus.ctrl_vld && (bus.ctrl_op == 2'b11) && (bus.ctrl_trd == ID);
            assign spawn_hit[gi] = bus.new_trd_vld && (spawn_id == ID);

            // A thread being killed or put to sleep this cycle must not issue.
            assign elig[gi] = (state_reg[gi] == TRD_RUN) && !kill_hit[gi] && !sleep_hit[gi];

            // Redirects to FREE threads are dropped, and a same-cycle kill wins.
            assign jmp_hit[gi] = bus.jmp_en && (bus.jmp_trd == ID) &&
                                 (state_reg[gi] != TRD_FREE) && !kill_hit[gi];

            assign issue_hit[gi] = !bus.stall && sel_vld && (sel_trd == ID);

            // The issue path already folds in a same-cycle redirect via sel_pc.
            assign pc_next[gi] = issue_hit[gi] ? sel_pc + 32'd4 :
                                 spawn_hit[gi] ? bus.ctrl_pc    :
                                 jmp_hit[gi]   ? bus.jmp_pc     :
                                                 pc_reg[gi];

            if (gi < NTRD) begin : g_live
                assign state_next[gi] =
                    kill_hit[gi]                                  ? TRD_FREE  :
                    spawn_hit[gi]                                 ? TRD_RUN   :
                    (sleep_hit[gi] && state_reg[gi] == TRD_RUN)   ? TRD_SLEEP :
                    (wake_hit[gi]  && state_reg[gi] == TRD_SLEEP) ? TRD_RUN   :
                                                                    state_reg[gi];
                assign active_next[gi] = (state_next[gi] != TRD_FREE);
            end else begin : g_pad
                assign state_next[gi] = TRD_FREE;
            end
        end
    endgenerate

    // Round-robin pick: scan from farthest (last_trd itself) to nearest
    // (last_trd+1) so the nearest eligible thread is the one that sticks.
    always_comb begin
        int idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel_trd = 3'd0;
        for (int k = NTRD; k >= 1; k--) begin
            idx = int'(last_trd_reg) + k;
            if (idx >= NTRD) begin
                idx = idx - NTRD;
            end
            if (elig[3'(idx)]) begin
                sel_vld = 1'b1;
                sel_trd = 3'(idx);
            end
        end
        sel_pc = (bus.jmp_en && bus.jmp_trd == sel_trd) ? bus.jmp_pc : pc_reg[sel_trd];
    end

    // Thread contexts, scheduler pointer and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                state_reg[i] <= (i == 0) ? TRD_RUN : TRD_FREE;
                pc_reg[i]    <= (i == 0) ? RESET_PC : 32'd0;
            end
            last_trd_reg    <= 3'(NTRD - 1);
            fetch_vld_reg   <= 1'b0;
            fetch_trd_reg   <= 3'd0;
            fetch_pc_reg    <= 32'd0;
            active_mask_reg <= {{(NTRD-1){1'b0}}, 1'b1};
        end else begin
            for (int i = 0; i < 8; i++) begin
                state_reg[i] <= state_next[i];
                pc_reg[i]    <= pc_next[i];
            end
            active_mask_reg <= active_next;
            if (!bus.stall) begin
                fetch_vld_reg <= sel_vld;
                if (sel_vld) begin
                    fetch_trd_reg <= sel_trd;
                    fetch_pc_reg  <= sel_pc;
                    last_trd_reg  <= sel_trd;
                end
            end
        end
    end

    assign bus.fetch_vld   = fetch_vld_reg;
    assign bus.fetch_trd   = fetch_trd_reg;
    assign bus.fetch_pc    = fetch_pc_reg;
    assign bus.active_mask = active_mask_reg;
endmodule

// File: tb/tb_trd_sched.sv
// Bench for trd_sched: a directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a thread-level
// reference model of the scheduler.
module tb_trd_sched;
    localparam int          NTRD = 8;
    localparam logic [31:0] RPC  = 32'h100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trd_sched_if #(.NTRD(NTRD)) bus ();

    trd_sched #(.NTRD(NTRD), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit          stall;
        bit          je;
        logic [2:0]  jt;
        logic [31:0] jp;
        bit          cv;
        logic [1:0]  op;
        logic [2:0]  ct;
        logic [31:0] cp;
    } in_t;

    typedef struct {
        in_t         in;
        bit          fv;
        logic [2:0]  ft;
        logic [31:0] fp;
        logic [7:0]  mask;
        bit          nv;
        logic [2:0]  nt;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: 0 = FREE, 1 = RUN, 2 = SLEEP
    int          m_st [NTRD];
    logic [31:0] m_pc [NTRD];
    int          m_last;
    bit          m_fv;
    logic [2:0]  m_ft;
    logic [31:0] m_fp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mkin(bit st, bit je, logic [2:0] jt, logic [31:0] jp,
                                 bit cv, logic [1:0] op, logic [2:0] ct, logic [31:0] cp);
        in_t r;
        r.stall = st; r.je = je; r.jt = jt; r.jp = jp;
        r.cv = cv; r.op = op; r.ct = ct; r.cp = cp;
        return r;
    endfunction

    function automatic vec_t mkv(in_t i, bit fv, logic [2:0] ft, logic [31:0] fp,
                                 logic [7:0] mask, bit nv, logic [2:0] nt);
        vec_t r;
        r.in = i; r.fv = fv; r.ft = ft; r.fp = fp; r.mask = mask; r.nv = nv; r.nt = nt;
        return r;
    endfunction

    function automatic in_t rnd_in();
        in_t r;
        r.stall = ($urandom_range(0, 4) == 0);
        r.je    = ($urandom_range(0, 3) == 0);
        r.jt    = 3'($urandom_range(0, 7));
        r.jp    = $urandom;
        r.cv    = ($urandom_range(0, 2) == 0);
        r.op    = 2'($urandom_range(0, 3));
        r.ct    = 3'($urandom_range(0, 7));
        r.cp    = $urandom;
        return r;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] r = 8'h0;
        for (int i = 0; i < NTRD; i++) r[i] = (m_st[i] != 0);
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NTRD; i++) begin
            m_st[i] = (i == 0) ? 1 : 0;
            m_pc[i] = (i == 0) ? RPC : 32'h0;
        end
        m_last = NTRD - 1;
        m_fv = 0; m_ft = 3'd0; m_fp = 32'h0;
    endtask

    task automatic drive(input in_t v);
        bus.stall    = v.stall;
        bus.jmp_en   = v.je;
        bus.jmp_trd  = v.jt;
        bus.jmp_pc   = v.jp;
        bus.ctrl_vld = v.cv;
        bus.ctrl_op  = v.op;
        bus.ctrl_trd = v.ct;
        bus.ctrl_pc  = v.cp;
    endtask

    // One clock cycle: apply inputs, check the combinational spawn grant,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle(input in_t v, output logic nv_s, output logic [2:0] nt_s);
        int spawn_id = -1;
        int t_sel    = -1;
        int t;
        logic [31:0] p = 32'h0;
        drive(v);
        #1;
        nv_s = bus.new_trd_vld;
        nt_s = bus.new_trd;
        if (v.cv && v.op == 2'b00) begin
            for (int i = 0; i < NTRD; i++)
                if (m_st[i] == 0 && spawn_id < 0) spawn_id = i;
        end
        chk("new_trd_vld", nv_s, (spawn_id >= 0));
        if (v.cv && v.op == 2'b00)
            chk("new_trd", nt_s, (spawn_id >= 0) ? spawn_id : 0);

        // Pick the next thread after last, among RUN threads not killed/slept now.
        if (!v.stall) begin
            for (int k = 1; k <= NTRD; k++) begin
                t = (m_last + k) % NTRD;
                if (m_st[t] == 1 && !(v.cv && (v.op == 2'b01 || v.op == 2'b10) && v.ct == t)) begin
                    t_sel = t;
                    break;
                end
            end
        end
        // Redirect lands first so an issue of the same thread sees it.
        if (v.je && v.jt < NTRD && m_st[v.jt] != 0 && !(v.cv && v.op == 2'b01 && v.ct == v.jt))
            m_pc[v.jt] = v.jp;
        if (t_sel >= 0) begin
            p = m_pc[t_sel];
            m_pc[t_sel] = p + 32'd4;
        end
        if (v.cv && v.ct < NTRD) begin
            case (v.op)
                2'b01: m_st[v.ct] = 0;
                2'b10: if (m_st[v.ct] == 1) m_st[v.ct] = 2;
                2'b11: if (m_st[v.ct] == 2) m_st[v.ct] = 1;
                default: ;
            endcase
        end
        if (spawn_id >= 0) begin
            m_st[spawn_id] = 1;
            m_pc[spawn_id] = v.cp;
        end
        if (!v.stall) begin
            m_fv = (t_sel >= 0);
            if (t_sel >= 0) begin
                m_ft = 3'(t_sel);
                m_fp = p;
                m_last = t_sel;
            end
        end

        @(posedge clk);
        #1;
        chk("fetch_vld", bus.fetch_vld, m_fv);
        if (m_fv) begin
            chk("fetch_trd", bus.fetch_trd, m_ft);
            chk("fetch_pc", bus.fetch_pc, m_fp);
        end
        chk("active_mask", bus.active_mask, m_mask());
    endtask

    task automatic do_reset(input bit rnd);
        rst = 1'b1;
        drive(rnd ? rnd_in() : mkin(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mkin(0, 0, 0, 0, 0, 0, 0, 0));
        m_reset();
        chk("rst_fetch_vld", bus.fetch_vld, 0);
        chk("rst_fetch_trd", bus.fetch_trd, 0);
        chk("rst_fetch_pc", bus.fetch_pc, 0);
        chk("rst_active_mask", bus.active_mask, 8'h01);
    endtask

    initial begin
        vec_t tbl [17];
        in_t  idle;
        logic nv;
        logic [2:0] nt;

        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mkv(idle, 1, 0, 32'h100, 8'h01, 0, 0);
        tbl[1]  = mkv(idle, 1, 0, 32'h104, 8'h01, 0, 0);
        tbl[2]  = mkv(idle, 1, 0, 32'h108, 8'h01, 0, 0);
        tbl[3]  = mkv(mkin(0, 0, 0, 0, 1, 2'b00, 0, 32'h400), 1, 0, 32'h10C, 8'h03, 1, 1);
        tbl[4]  = mkv(mkin(0, 0, 0, 0, 1, 2'b00, 0, 32'h800), 1, 1, 32'h400, 8'h07, 1, 2);
        tbl[5]  = mkv(idle, 1, 2, 32'h800, 8'h07, 0, 0);
        tbl[6]  = mkv(idle, 1, 0, 32'h110, 8'h07, 0, 0);
        tbl[7]  = mkv(idle, 1, 1, 32'h404, 8'h07, 0, 0);
        tbl[8]  = mkv(mkin(1, 0, 0, 0, 1, 2'b01, 1, 0), 1, 1, 32'h404, 8'h05, 0, 0);
        tbl[9]  = mkv(mkin(1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 32'h404, 8'h05, 0, 0);
        tbl[10] = mkv(mkin(1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 32'h404, 8'h05, 0, 0);
        tbl[11] = mkv(idle, 1, 2, 32'h804, 8'h05, 0, 0);
        tbl[12] = mkv(idle, 1, 0, 32'h114, 8'h05, 0, 0);
        tbl[13] = mkv(idle, 1, 2, 32'h808, 8'h05, 0, 0);
        tbl[14] = mkv(mkin(0, 1, 0, 32'h2000, 0, 0, 0, 0), 1, 0, 32'h2000, 8'h05, 0, 0);
        tbl[15] = mkv(idle, 1, 2, 32'h80C, 8'h05, 0, 0);
        tbl[16] = mkv(idle, 1, 0, 32'h2004, 8'h05, 0, 0);

        rst = 1'b1;
        drive(idle);
        do_reset(0);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].in, nv, nt);
            chk($sformatf("tbl%0d_new_vld", i), nv, tbl[i].nv);
            if (tbl[i].nv) chk($sformatf("tbl%0d_new_trd", i), nt, tbl[i].nt);
            chk($sformatf("tbl%0d_fetch_vld", i), bus.fetch_vld, tbl[i].fv);
            chk($sformatf("tbl%0d_fetch_trd", i), bus.fetch_trd, tbl[i].ft);
            chk($sformatf("tbl%0d_fetch_pc", i), bus.fetch_pc, tbl[i].fp);
            chk($sformatf("tbl%0d_mask", i), bus.active_mask, tbl[i].mask);
        end

        // All threads busy, an extra spawn is refused, a kill frees slot 3
        do_reset(0);
        for (int i = 1; i < NTRD; i++) begin
            cycle(mkin(0, 0, 0, 0, 1, 2'b00, 0, 32'h1000 * i), nv, nt);
            chk("fill_new_trd", nt, i);
        end
        cycle(mkin(0, 0, 0, 0, 1, 2'b00, 0, 32'hDEAD0), nv, nt);
        chk("full_new_vld", nv, 0);
        chk("full_new_trd", nt, 0);
        chk("full_mask", bus.active_mask, 8'hFF);
        cycle(mkin(0, 0, 0, 0, 1, 2'b01, 3, 0), nv, nt);
        cycle(mkin(0, 0, 0, 0, 1, 2'b00, 0, 32'h3300), nv, nt);
        chk("respawn_new_trd", nt, 3);

        // Sleeping the only runnable thread, then waking it
        do_reset(0);
        cycle(idle, nv, nt);
        cycle(idle, nv, nt);
        cycle(mkin(0, 0, 0, 0, 1, 2'b10, 0, 0), nv, nt);
        chk("sleep_fetch_vld", bus.fetch_vld, 0);
        cycle(idle, nv, nt);
        cycle(idle, nv, nt);
        cycle(mkin(0, 0, 0, 0, 1, 2'b11, 0, 0), nv, nt);
        chk("wake_same_cycle_vld", bus.fetch_vld, 0);
        cycle(idle, nv, nt);
        chk("wake_fetch_vld", bus.fetch_vld, 1);
        chk("wake_fetch_pc", bus.fetch_pc, 32'h108);

        // Randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else cycle(rnd_in(), nv, nt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/trd_sched.md
# trd_sched

Hardware thread scheduler and context controller for the multithreaded pipeline. It holds a state and a PC for each hardware thread, and each unstalled cycle it picks one runnable thread round-robin and issues that thread's PC to fetch. It services spawn, kill, sleep and wake requests from the thread-control path. It also applies jump redirects resolved in the execute stage to the owning thread's PC.

## Interface
- NTRD, 8, number of hardware threads (2..8); thread ids are always 3 bits wide
- RESET_PC, 32'h0, start PC of thread 0 after reset

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes issue
- jmp_en  in  1  redirect request for thread jmp_trd
- jmp_trd  in  3  thread being redirected
- jmp_pc  in  32  redirect target
- ctrl_vld  in  1  thread-control request valid
- ctrl_op  in  2  00 spawn, 01 kill, 10 sleep, 11 wake
- ctrl_trd  in  3  target thread for kill, sleep or wake
- ctrl_pc  in  32  start PC for spawn
- new_trd  out  3  id allocated by a spawn (combinational)
- new_trd_vld  out  1  spawn accepted this cycle (combinational)
- fetch_vld  out  1  fetch_trd/fetch_pc valid (registered)
- fetch_trd  out  3  thread issued to fetch (registered)
- fetch_pc  out  32  PC issued to fetch (registered)
- active_mask  out  NTRD  bit i = thread i is not FREE (registered)

## Operation
- Per-thread state: FREE, RUN, SLEEP. Per-thread registers: 32-bit pc; scheduler keeps a 3-bit last_trd.
- Reset:
  - thread 0 goes to RUN with pc=RESET_PC; all other threads go to FREE with pc=0.
  - last_trd=NTRD-1, so thread 0 is picked first.
  - fetch_vld=0, fetch_trd=0, fetch_pc=0, active_mask=1.
- Spawn (ctrl_vld, op 00):
  - Allocates the lowest-id FREE thread, judged on current-cycle state.
  - That thread's state becomes RUN and its pc becomes ctrl_pc.
  - new_trd=id and new_trd_vld=1 in the same cycle.
  - If no thread is FREE: new_trd_vld=0, new_trd=0, no state change.
- Kill (op 01): ctrl_trd goes to FREE from any state. Killing a FREE thread does nothing.
- Sleep (op 10): RUN goes to SLEEP; any other state is unchanged.
- Wake (op 11): SLEEP goes to RUN; any other state is unchanged. The pc is preserved across sleep and wake.
- Control ops and redirects are applied even while stall=1. Only issue freezes during stall.
- Redirect: jmp_en sets pc[jmp_trd]=jmp_pc.
  - If jmp_trd is FREE, the redirect is ignored.
  - If jmp_trd is killed in the same cycle, kill wins.
- Issue (stall=0):
  - Eligible threads are RUN and not the target of a kill or sleep this cycle.
  - Selected thread T is the first eligible thread scanning last_trd+1, last_trd+2, … wrapping modulo NTRD. last_trd itself is scanned last.
  - Registered next cycle: fetch_vld=1, fetch_trd=T, fetch_pc=P, last_trd=T, pc[T]=P+4.
  - P is jmp_pc if jmp_en and jmp_trd==T (redirect bypass); otherwise P is pc[T].
  - pc wraps modulo 2^32.
  - If no thread is eligible: fetch_vld=0, and last_trd and all pcs are unchanged (apart from redirects).
- Issue (stall=1): fetch_vld, fetch_trd, fetch_pc and last_trd hold, and no pc increments.
- Threads spawned or woken this cycle are not eligible until the next cycle.

## Timing
- Issue latency is 1 cycle: the selection made in cycle N appears on the fetch outputs in cycle N+1.
- Peak issue rate is one fetch per cycle. With k threads in RUN, each thread issues once every k unstalled cycles.
- The spawn grant (new_trd, new_trd_vld) is combinational in the request cycle; the state update is visible from N+1.
- A redirect in cycle N:
  - is seen by an issue of the same thread in cycle N (via bypass);
  - otherwise is held in pc[jmp_trd] for that thread's next issue.
- At most one control op per cycle; ctrl_vld is a single-cycle pulse with no backpressure.
- Reset asserted mid-operation takes priority over every input in that cycle. The reset values hold the following cycle.

## Test plan
- Reset, RESET_PC=0x100, no ctrl input, stall=0 -> fetch_pc sequence 0x100, 0x104, 0x108 with fetch_trd=0 and fetch_vld=1 from the cycle after reset release.
- Spawn with ctrl_pc=0x400, then a second spawn with ctrl_pc=0x800 -> new_trd=1 then 2. Issue then rotates thread 0, 1, 2, 0 with pcs advancing by 4 per thread. active_mask=0b111.
- Hold stall=1 for 3 cycles while a kill of thread 1 is issued -> fetch outputs hold for all 3 cycles. After release, rotation skips thread 1 and active_mask bit 1 clears.
- Redirect jmp_trd=0, jmp_pc=0x2000 in the cycle thread 0 is selected -> fetch_pc=0x2000, and thread 0's next issue is at 0x2004.
- Spawn 7 times (all 8 threads busy), then one more spawn -> new_trd_vld=0 and no state change. Kill thread 3, then spawn -> new_trd=3.
- Sleep thread 0 when it is the only RUN thread -> fetch_vld=0. Wake thread 0 -> issue resumes at the preserved pc one cycle after the wake.
